// File: rtl/unibus_npr_master.sv
// Unibus NPR bus master: arbitrates for the bus with NPR/NPG/SACK, takes BBSY,
// then runs one DATI, DATO or DATOB cycle with the MSYN/SSYN handshake on behalf
// of a local requester. A missing SSYN ends the cycle with an error.
module unibus_npr_master #(
    parameter int DESKEW  = 4,
    parameter int TIMEOUT = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [17:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    input  logic        bus_init,
    input  logic        bus_npg_in,
    output logic        bus_npg_out,
    output logic        bus_npr,
    output logic        bus_sack_out,
    input  logic        bus_bbsy,
    output logic        bus_bbsy_out,
    input  logic        bus_ssyn,
    output logic        bus_msyn_out,
    output logic [17:0] bus_addr_out,
    output logic        bus_c0_out,
    output logic        bus_c1_out,
    input  logic [15:0] bus_d,
    output logic [15:0] bus_d_out
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DESKEW + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DLAST = DW'(DESKEW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SACK,
        S_ADDR,
        S_MSYN,
        S_LATCH,
        S_END
    } state_t;

    state_t        state;
    logic          lat_write;
    logic          lat_byte;
    logic [17:0]   lat_addr;
    logic [15:0]   lat_wdata;
    logic          timed_out;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt;

    assign busy = (state != S_IDLE);

    // The grant chain is broken while we are asking for or acknowledging the bus
    assign bus_npg_out = (state == S_REQ || state == S_SACK) ? 1'b0 : bus_npg_in;

    // Master sequencer: arbitration, address/data phase, handshake, release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            lat_write    <= 1'b0;
            lat_byte     <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            timed_out    <= 1'b0;
            dcnt         <= '0;
            tcnt         <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            bus_npr      <= 1'b0;
            bus_sack_out <= 1'b0;
            bus_bbsy_out <= 1'b0;
            bus_msyn_out <= 1'b0;
            bus_addr_out <= '0;
            bus_c0_out   <= 1'b0;
            bus_c1_out   <= 1'b0;
            bus_d_out    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (bus_init) begin
                state        <= S_IDLE;
                bus_npr      <= 1'b0;
                bus_sack_out <= 1'b0;
                bus_bbsy_out <= 1'b0;
                bus_msyn_out <= 1'b0;
                bus_addr_out <= '0;
                bus_c0_out   <= 1'b0;
                bus_c1_out   <= 1'b0;
                bus_d_out    <= '0;
                if (state != S_IDLE) begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req) begin
                            lat_write <= req_write;
                            lat_byte  <= req_byte;
                            lat_addr  <= req_addr;
                            lat_wdata <= req_wdata;
                            timed_out <= 1'b0;
                            bus_npr   <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (bus_npg_in) begin
                            bus_npr      <= 1'b0;
                            bus_sack_out <= 1'b1;
                            state        <= S_SACK;
                        end
                    end
                    S_SACK: begin
                        if (!bus_npg_in && !bus_bbsy && !bus_ssyn) begin
                            bus_sack_out <= 1'b0;
                            bus_bbsy_out <= 1'b1;
                            bus_addr_out <= lat_addr;
                            bus_c1_out   <= lat_write;
                            bus_c0_out   <= lat_write & lat_byte;
                            bus_d_out    <= lat_write ? lat_wdata : 16'h0000;
                            dcnt         <= '0;
                            state        <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (dcnt == DLAST) begin
                            bus_msyn_out <= 1'b1;
                            tcnt         <= '0;
                            state        <= S_MSYN;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    S_MSYN: begin
                        if (bus_ssyn) begin
                            dcnt <= '0;
                            if (lat_write) begin
                                bus_msyn_out <= 1'b0;
                                state        <= S_END;
                            end else begin
                                state <= S_LATCH;
                            end
                        end else if (tcnt == TLAST) begin
                            bus_msyn_out <= 1'b0;
                            timed_out    <= 1'b1;
                            dcnt         <= '0;
                            state        <= S_END;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_LATCH: begin
                        if (dcnt == DLAST) begin
                            rdata        <= bus_d;
                            bus_msyn_out <= 1'b0;
                            dcnt         <= '0;
                            state        <= S_END;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    S_END: begin
                        if (bus_ssyn && !timed_out) begin
                            dcnt <= '0;
                        end else if (dcnt == DLAST) begin
                            bus_bbsy_out <= 1'b0;
                            bus_addr_out <= '0;
                            bus_c0_out   <= 1'b0;
                            bus_c1_out   <= 1'b0;
                            bus_d_out    <= '0;
                            done         <= 1'b1;
                            err          <= timed_out;
                            state        <= S_IDLE;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
